// File: rtl/qupls_alu_dispatch_queue.sv
// In-order dispatch queue for ALU-class instructions; non-ALU instructions are
// consumed and dropped. Circular buffer with valid/ready on both sides and flush.
module qupls_alu_dispatch_queue #(
    parameter int DEPTH = 8,
    parameter int IW    = 41,
    parameter int TW    = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [IW-1:0]              in_instr,
    input  logic [TW-1:0]              in_tag,
    input  logic                       in_alu,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [IW-1:0]              out_instr,
    output logic [TW-1:0]              out_tag,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [IW-1:0] mem_instr [DEPTH];
    logic [TW-1:0] mem_tag   [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          full;
    logic          empty;
    logic          accept;
    logic          enq;
    logic          deq;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign in_ready  = ~full;
    assign out_valid = ~empty;

    assign accept = in_valid & in_ready;
    assign enq    = accept & in_alu & ~flush;
    assign deq    = out_valid & out_ready & ~flush;

    // Head is read straight from storage; forced to zero when nothing is queued.
    assign out_instr = empty ? '0 : mem_instr[rd_ptr];
    assign out_tag   = empty ? '0 : mem_tag[rd_ptr];

    always_ff @(posedge clk) begin
        if (enq) begin
            mem_instr[wr_ptr] <= in_instr;
            mem_tag[wr_ptr]   <= in_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + AW'(1);
            if (deq) rd_ptr <= rd_ptr + AW'(1);
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_qupls_alu_dispatch_queue.sv
// Directed self-checking bench for the ALU dispatch queue.
`timescale 1ns/1ps
module tb_qupls_alu_dispatch_queue;

    localparam int DEPTH = 8;
    localparam int IW    = 41;
    localparam int TW    = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_instr;
    logic [TW-1:0] in_tag;
    logic          in_alu;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_instr;
    logic [TW-1:0] out_tag;
    logic [3:0]    count;

    int checks = 0;
    int errors = 0;

    qupls_alu_dispatch_queue #(.DEPTH(DEPTH), .IW(IW), .TW(TW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_tag    (in_tag),
        .in_alu    (in_alu),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_tag   (out_tag),
        .count     (count)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] instr_of(input logic [TW-1:0] t);
        return {t, 35'h1_2345_6789};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_enq(input logic [TW-1:0] t);
        in_valid = 1'b1;
        in_alu   = 1'b1;
        in_tag   = t;
        in_instr = instr_of(t);
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_alu    = 1'b0;
        in_tag    = '0;
        in_instr  = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== 4'd0) begin
            errors++;
            $display("FAIL reset_flags out_valid=%b in_ready=%b count=%0d want 0 1 0", out_valid, in_ready, count);
        end
        checks++;
        if (out_tag !== '0 || out_instr !== '0) begin
            errors++;
            $display("FAIL reset_outputs out_tag=%0d out_instr=%h want 0 0", out_tag, out_instr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        drive_enq(6'd5);
        tick();
        idle_inputs();
        checks++;
        if (out_valid !== 1'b1 || out_tag !== 6'd5 || count !== 4'd1) begin
            errors++;
            $display("FAIL single_enq out_valid=%b tag=%0d count=%0d want 1 5 1", out_valid, out_tag, count);
        end
        checks++;
        if (out_instr !== instr_of(6'd5)) begin
            errors++;
            $display("FAIL single_instr got %h want %h", out_instr, instr_of(6'd5));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || count !== 4'd0 || out_tag !== '0) begin
            errors++;
            $display("FAIL single_deq out_valid=%b count=%0d tag=%0d want 0 0 0", out_valid, count, out_tag);
        end
    endtask

    task automatic test_non_alu();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_alu   = 1'b0;
            in_tag   = TW'(20 + i);
            in_instr = instr_of(in_tag);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL non_alu_ready cycle %0d got %b want 1", i, in_ready);
            end
            tick();
            checks++;
            if (count !== 4'd0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL non_alu_drop cycle %0d count=%0d out_valid=%b want 0 0", i, count, out_valid);
            end
        end
        idle_inputs();
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL fill_ready at count %0d got %b want 1", i, in_ready);
            end
            drive_enq(TW'(i));
            tick();
        end
        drive_enq(6'd9);
        checks++;
        if (count !== 4'd8 || in_ready !== 1'b0 || out_tag !== 6'd0) begin
            errors++;
            $display("FAIL fill_full count=%0d in_ready=%b head=%0d want 8 0 0", count, in_ready, out_tag);
        end
        tick();
        checks++;
        if (count !== 4'd8 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_hold count=%0d in_ready=%b want 8 0", count, in_ready);
        end
        out_ready = 1'b1;
        #2;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_deq_same_cycle in_ready=%b want 0", in_ready);
        end
        tick();
        in_valid = 1'b0;
        in_alu   = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (count !== 4'd7 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_deq_next count=%0d in_ready=%b want 7 1", count, in_ready);
        end
        for (int i = 1; i < DEPTH; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_tag !== TW'(i) || out_instr !== instr_of(TW'(i))) begin
                errors++;
                $display("FAIL drain_order slot %0d got valid=%b tag=%0d want 1 %0d", i, out_valid, out_tag, i);
            end
            out_ready = 1'b1;
            tick();
        end
        out_ready = 1'b0;
        checks++;
        if (count !== 4'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty count=%0d out_valid=%b want 0 0", count, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        drive_enq(6'd10);
        tick();
        for (int i = 0; i < 20; i++) begin
            drive_enq(TW'(11 + i));
            out_ready = 1'b1;
            checks++;
            if (out_valid !== 1'b1 || out_tag !== TW'(10 + i)) begin
                errors++;
                $display("FAIL b2b_order step %0d got valid=%b tag=%0d want 1 %0d", i, out_valid, out_tag, 10 + i);
            end
            tick();
            checks++;
            if (count !== 4'd1) begin
                errors++;
                $display("FAIL b2b_count step %0d got %0d want 1", i, count);
            end
        end
        in_valid = 1'b0;
        in_alu   = 1'b0;
        checks++;
        if (out_tag !== 6'd30) begin
            errors++;
            $display("FAIL b2b_last got tag %0d want 30", out_tag);
        end
        tick();
        out_ready = 1'b0;
        checks++;
        if (count !== 4'd0) begin
            errors++;
            $display("FAIL b2b_drain count=%0d want 0", count);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 6; i++) begin
            drive_enq(TW'(30 + i));
            tick();
        end
        drive_enq(6'd40);
        out_ready = 1'b1;
        flush     = 1'b1;
        #2;
        checks++;
        if (count !== 4'd6 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_pre count=%0d in_ready=%b want 6 1", count, in_ready);
        end
        tick();
        idle_inputs();
        checks++;
        if (count !== 4'd0 || out_valid !== 1'b0 || out_tag !== '0) begin
            errors++;
            $display("FAIL flush_clear count=%0d out_valid=%b tag=%0d want 0 0 0", count, out_valid, out_tag);
        end
        drive_enq(6'd41);
        tick();
        idle_inputs();
        checks++;
        if (count !== 4'd1 || out_tag !== 6'd41) begin
            errors++;
            $display("FAIL flush_after count=%0d head=%0d want 1 41", count, out_tag);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            drive_enq(TW'(50 + i));
            tick();
        end
        idle_inputs();
        checks++;
        if (count !== 4'd3 || out_tag !== 6'd50) begin
            errors++;
            $display("FAIL async_pre count=%0d head=%0d want 3 50", count, out_tag);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || count !== 4'd0 || in_ready !== 1'b1 || out_tag !== '0) begin
            errors++;
            $display("FAIL async_reset out_valid=%b count=%0d in_ready=%b tag=%0d want 0 0 1 0",
                     out_valid, count, in_ready, out_tag);
        end
        #2;
        rst_n = 1'b1;
        tick();
        drive_enq(6'd7);
        tick();
        idle_inputs();
        checks++;
        if (count !== 4'd1 || out_tag !== 6'd7) begin
            errors++;
            $display("FAIL async_after count=%0d head=%0d want 1 7", count, out_tag);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_non_alu();
        test_fill();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
